// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared encodings and constants for the iterative divider
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam int DivIterations = 32;

    localparam logic [7:0] ALU_OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] ALU_OP_DIVU = 8'b0001_1011;

endpackage

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - EX-to-divider request/result bundle
interface div_ctrl_if #(
    parameter int DATA_W = 32
);
    logic                  start_i;
    logic                  annul_i;
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;

    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift, trial subtract, select
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   rem,
    input  logic              dividend_msb,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W:0]   rem_next,
    output logic              q_bit
);
    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] diff;

    // One extra guard bit so the borrow of the trial subtract is visible.
    assign shifted  = {rem, dividend_msb};
    assign diff     = shifted - {2'b00, divisor};
    assign q_bit    = ~diff[DATA_W+1];
    assign rem_next = q_bit ? diff[DATA_W:0] : shifted[DATA_W:0];
endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle DIV/DIVU sequencer returning {remainder, quotient}
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    div_ctrl_if.slave   bus
);
    div_state_t state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   rem_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] dvs_q;
    logic              neg_quot_q;
    logic              neg_rem_q;

    logic [2*DATA_W-1:0] result_q;
    logic                ready_q;
    logic                busy_q;

    logic load, step, finish, zero_done, clear;

    logic [DATA_W:0]   rem_next;
    logic              q_bit;
    logic [DATA_W-1:0] quot_next;
    logic [DATA_W-1:0] quot_fix;
    logic [DATA_W-1:0] rem_fix;
    logic [DATA_W-1:0] dvd_abs;
    logic [DATA_W-1:0] dvs_abs;
    logic              dvs_zero;

    assign dvs_zero = (bus.opdata2_i == '0);
    assign dvd_abs  = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign dvs_abs  = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem          (rem_q),
        .dividend_msb (dvd_q[DATA_W-1]),
        .divisor      (dvs_q),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    // The dividend register fills with quotient bits as it shifts out.
    assign quot_next = {dvd_q[DATA_W-2:0], q_bit};
    assign quot_fix  = neg_quot_q ? -quot_next : quot_next;
    assign rem_fix   = neg_rem_q ? -rem_next[DATA_W-1:0] : rem_next[DATA_W-1:0];

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        zero_done  = 1'b0;
        clear      = 1'b0;
        case (state)
            DivFree: begin
                if (bus.start_i == DivStart && !bus.annul_i) begin
                    if (dvs_zero) begin
                        state_next = DivByZero;
                    end else begin
                        state_next = DivOn;
                        load       = 1'b1;
                    end
                end
            end
            DivByZero: begin
                if (bus.annul_i) begin
                    state_next = DivFree;
                end else begin
                    state_next = DivEnd;
                    zero_done  = 1'b1;
                end
            end
            DivOn: begin
                if (bus.annul_i) begin
                    state_next = DivFree;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_W'(DivIterations - 1)) begin
                        state_next = DivEnd;
                        finish     = 1'b1;
                    end
                end
            end
            DivEnd: begin
                if (bus.start_i == DivStop || bus.annul_i) begin
                    state_next = DivFree;
                    clear      = 1'b1;
                end
            end
            default: state_next = DivFree;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DivFree;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
            busy_q     <= 1'b0;
        end else begin
            busy_q <= (state_next != DivFree);
            if (load) begin
                cnt        <= '0;
                rem_q      <= '0;
                dvd_q      <= dvd_abs;
                dvs_q      <= dvs_abs;
                neg_quot_q <= bus.signed_div_i && (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                neg_rem_q  <= bus.signed_div_i && bus.opdata1_i[DATA_W-1];
            end
            if (step) begin
                rem_q <= rem_next;
                dvd_q <= quot_next;
                cnt   <= cnt + 1'b1;
            end
            if (finish) begin
                result_q <= {rem_fix, quot_fix};
                ready_q  <= DivResultReady;
            end
            if (zero_done) begin
                result_q <= '0;
                ready_q  <= DivResultReady;
            end
            if (clear) begin
                result_q <= '0;
                ready_q  <= DivResultNotReady;
            end
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = busy_q;
endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed vector bench for div_ctrl
module tb_div_ctrl;
    logic clk;
    logic rst;

    div_ctrl_if #(.DATA_W(32)) bus ();

    div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Operands are scrambled after the third edge; the latched values must win.
    task automatic run_div(input vec_t v, input bit hold5);
        int  n;
        int  busy_n;
        bit  got;
        bus.signed_div_i = v.sgn;
        bus.opdata1_i    = v.a;
        bus.opdata2_i    = v.b;
        bus.start_i      = 1'b1;
        n = 0;
        busy_n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy_o) busy_n++;
            if (bus.ready_o) got = 1'b1;
            else if (n == 3) begin
                bus.opdata1_i = ~v.a;
                bus.opdata2_i = v.b ^ 32'h5;
            end
        end
        check("latency", 64'(n), 64'(v.lat));
        check("result", bus.result_o, v.exp);
        check("busy_cycles", 64'(busy_n), 64'(v.lat));
        if (hold5) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                check("hold_ready", 64'(bus.ready_o), 64'd1);
                check("hold_result", bus.result_o, v.exp);
                check("hold_busy", 64'(bus.busy_o), 64'd1);
            end
        end
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check("drop_ready", 64'(bus.ready_o), 64'd0);
        check("drop_result", bus.result_o, 64'd0);
        check("drop_busy", 64'(bus.busy_o), 64'd0);
    endtask

    vec_t vecs[10];
    vec_t v;
    bit   seen;

    initial begin
        vecs[0] = '{1'b0, 32'd7,          32'd2,          {32'h1,        32'h3},        33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'h1,        32'hFFFFFFFD}, 33};
        vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0,        32'h80000000}, 33};
        vecs[4] = '{1'b0, 32'h12345678,   32'd0,          64'h0,                        2};
        vecs[5] = '{1'b0, 32'd3,          32'd10,         {32'h3,        32'h0},        33};
        vecs[6] = '{1'b0, 32'd100,        32'd7,          {32'h2,        32'hE},        33};
        vecs[7] = '{1'b0, 32'hFFFFFFF9,   32'd2,          {32'h1,        32'h7FFFFFFC}, 33};
        vecs[8] = '{1'b1, 32'hFFFFFF9C,   32'd7,          {32'hFFFFFFFE, 32'hFFFFFFF2}, 33};
        vecs[9] = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h0,        32'hFFFFFFFF}, 33};

        rst = 1'b1;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", bus.result_o, 64'd0);
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_div(vecs[i], 1'b0);
        end

        // Annul after ten RUN iterations, then a clean request.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd50;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        check("annul_busy", 64'(bus.busy_o), 64'd0);
        check("annul_ready", 64'(bus.ready_o), 64'd0);
        check("annul_result", bus.result_o, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) seen = 1'b1;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        run_div(vecs[6], 1'b0);

        // Asynchronous reset mid-RUN, between clock edges.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd7;
        bus.opdata2_i    = 32'd2;
        bus.start_i      = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(bus.busy_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(bus.busy_o), 64'd0);
        check("arst_ready", 64'(bus.ready_o), 64'd0);
        check("arst_result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_div(vecs[1], 1'b0);

        // Start held after completion: stays in DONE with a stable result.
        v = '{1'b0, 32'h12345678, 32'h00000100, {32'h78, 32'h00123456}, 33};
        run_div(v, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
